// File: rtl/parking_lane_arbiter_if.sv
// Parking lane arbiter bus: requests, crossing events, gates, BCD count.
// master drives requests/events/tick; slave is the arbiter.
interface parking_lane_arbiter_if;
  logic       tick;
  logic       entry_req;
  logic       exit_req;
  logic       vehicle_entered;
  logic       vehicle_exited;
  logic       gate_in;
  logic       gate_out;
  logic [3:0] unidades;
  logic [3:0] decenas;
  logic       full;
  logic       empty;
  logic       timeout_err;
  logic       wrong_way;
  logic       intrusion;

  modport master (
    output tick, entry_req, exit_req,
    output vehicle_entered, vehicle_exited,
    input  gate_in, gate_out, unidades, decenas,
    input  full, empty, timeout_err, wrong_way, intrusion
  );

  modport slave (
    input  tick, entry_req, exit_req,
    input  vehicle_entered, vehicle_exited,
    output gate_in, gate_out, unidades, decenas,
    output full, empty, timeout_err, wrong_way, intrusion
  );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Single-lane parking gate arbiter with BCD occupancy count.
// Ports: clk, reset_btn (async low), bus (slave). Option: PARKING_INTRUSION_EN.
module parking_lane_arbiter #(
  parameter int unsigned CAPACITY      = 99,
  parameter int unsigned TIMEOUT_TICKS = 500,
  parameter int unsigned HOLD_TICKS    = 20
) (
  input logic clk,
  input logic reset_btn,
  parking_lane_arbiter_if.slave bus
);

  localparam int unsigned CMAX =
    (TIMEOUT_TICKS > HOLD_TICKS) ? TIMEOUT_TICKS : HOLD_TICKS;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [3:0] CAP_T = 4'(CAPACITY / 10);
  localparam logic [3:0] CAP_U = 4'(CAPACITY % 10);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE, GRANT_IN, GRANT_OUT, CLEAR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          run;
  logic [CW-1:0] cnt_q;
  logic          last_out_q, last_out_d;
  logic [3:0]    units_q, units_d;
  logic [3:0]    tens_q, tens_d;
  logic          gin_q, gout_q;
  logic          to_q, to_d;
  logic          ww_q, ww_d;
  logic          inc, dec, stray;
  logic          full, empty;
  logic          ent_ok, ex_ok;
  logic          to_hit, ho_hit;

  // Assert is immediate; release takes two edges.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) sync_q <= '0;
    else            sync_q <= {sync_q[0], 1'b1};
  end

  assign run = sync_q[1];

  assign full  = (tens_q == CAP_T) && (units_q == CAP_U);
  assign empty = (tens_q == 4'd0) && (units_q == 4'd0);

  assign ent_ok = bus.entry_req && !full;
  assign ex_ok  = bus.exit_req && !empty;
  assign to_hit = bus.tick && (cnt_q == TO_LAST);
  assign ho_hit = bus.tick && (cnt_q == HO_LAST);

  always_comb begin
    state_d    = state_q;
    last_out_d = last_out_q;
    inc        = 1'b0;
    dec        = 1'b0;
    stray      = 1'b0;
    to_d       = 1'b0;
    ww_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        stray = 1'b1;
        // Entry wins unless exit also eligible and entry went last.
        if (ent_ok && (!ex_ok || last_out_q)) begin
          state_d    = GRANT_IN;
          last_out_d = 1'b0;
        end else if (ex_ok) begin
          state_d    = GRANT_OUT;
          last_out_d = 1'b1;
        end
      end
      GRANT_IN: begin
        ww_d = bus.vehicle_exited;
        if (bus.vehicle_entered) begin
          inc     = 1'b1;
          state_d = CLEAR;
        end else if (to_hit) begin
          to_d    = 1'b1;
          state_d = CLEAR;
        end
      end
      GRANT_OUT: begin
        ww_d = bus.vehicle_entered;
        if (bus.vehicle_exited) begin
          dec     = 1'b1;
          state_d = CLEAR;
        end else if (to_hit) begin
          to_d    = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        stray = 1'b1;
        if (ho_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stray) begin
      inc = bus.vehicle_entered && !bus.vehicle_exited;
      dec = bus.vehicle_exited && !bus.vehicle_entered;
    end
    if (!run) begin
      state_d    = state_q;
      last_out_d = last_out_q;
      inc        = 1'b0;
      dec        = 1'b0;
      stray      = 1'b0;
      to_d       = 1'b0;
      ww_d       = 1'b0;
    end
  end

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    unique case (1'b1)
      (inc && !full): begin
        if (units_q == 4'd9) begin
          units_d = 4'd0;
          tens_d  = tens_q + 4'd1;
        end else begin
          units_d = units_q + 4'd1;
        end
      end
      (dec && !empty): begin
        if (units_q == 4'd0) begin
          units_d = 4'd9;
          tens_d  = tens_q - 4'd1;
        end else begin
          units_d = units_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_out_q <= 1'b1;
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      gin_q      <= 1'b0;
      gout_q     <= 1'b0;
      to_q       <= 1'b0;
      ww_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_out_q <= last_out_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      gin_q      <= (state_d == GRANT_IN);
      gout_q     <= (state_d == GRANT_OUT);
      to_q       <= to_d;
      ww_q       <= ww_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (run && bus.tick && state_q != IDLE)
        cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef PARKING_INTRUSION_EN
  logic intr_q;

  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) intr_q <= 1'b0;
    else intr_q <= stray && (bus.vehicle_entered || bus.vehicle_exited);
  end

  assign bus.intrusion = intr_q;
`else
  assign bus.intrusion = 1'b0;
`endif

  assign bus.gate_in     = gin_q;
  assign bus.gate_out    = gout_q;
  assign bus.unidades    = units_q;
  assign bus.decenas     = tens_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.timeout_err = to_q;
  assign bus.wrong_way   = ww_q;

endmodule
